// File: rtl/writeback_arbiter.sv
// writeback_arbiter: register-file write port, ALU first, long-latency FIFO drains idle slots.
// Optional read bypass from the registered write port when WB_BYPASS_EN is defined.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ll_valid_i,
  output logic            ll_ready_o,
  input  logic [4:0]      ll_rd_i,
  input  logic [XLEN-1:0] ll_data_i,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_rd_i,
  output logic [31:0]     pending_o,
  output logic            RegWrite_o,
  output logic [4:0]      RDaddr_o,
  output logic [XLEN-1:0] RDdata_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic            rs1_hit_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic            rs2_hit_o,
  output logic [XLEN-1:0] rs2_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            alu_sel;
  logic            deq;
  logic            enq;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic [31:0]     pend_d;

  assign alu_sel    = alu_valid_i && (alu_rd_i != 5'd0);
  assign deq        = !alu_sel && (count != '0);
  assign ll_ready_o = !rst_i && (count < FULL);
  // rd=0 results complete the handshake but are dropped
  assign enq        = ll_valid_i && ll_ready_o && (ll_rd_i != 5'd0);
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_rd[wr_ptr]   <= ll_rd_i;
      fifo_data[wr_ptr] <= ll_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq) count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else if (alu_sel) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= alu_rd_i;
      RDdata_o   <= alu_data_i;
    end else if (deq) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= head_rd;
      RDdata_o   <= head_data;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end

  // set is applied after clear so a same-cycle issue wins
  always_comb begin
    pend_d = pending_o;
    if (deq) pend_d[head_rd] = 1'b0;
    if (issue_valid_i) pend_d[issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_o <= '0;
    else       pending_o <= pend_d;
  end

`ifdef WB_BYPASS_EN
  assign rs1_hit_o  = RegWrite_o && (RDaddr_o != 5'd0)
                   && (rs1_addr_i == RDaddr_o);
  assign rs2_hit_o  = RegWrite_o && (RDaddr_o != 5'd0)
                   && (rs2_addr_i == RDaddr_o);
  assign rs1_data_o = rs1_hit_o ? RDdata_o : '0;
  assign rs2_data_o = rs2_hit_o ? RDdata_o : '0;
`else
  logic unused_rs;
  assign unused_rs  = ^{rs1_addr_i, rs2_addr_i};
  assign rs1_hit_o  = 1'b0;
  assign rs2_hit_o  = 1'b0;
  assign rs1_data_o = '0;
  assign rs2_data_o = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed + random checks of writeback_arbiter
// against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;

  logic        ll_ready;
  logic [31:0] pend;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        hit1, hit2;
  logic [31:0] bd1, bd2;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  writeback_arbiter #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .ll_valid_i(ll_valid), .ll_ready_o(ll_ready),
    .ll_rd_i(ll_rd), .ll_data_i(ll_data),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .pending_o(pend),
    .RegWrite_o(we), .RDaddr_o(waddr), .RDdata_o(wdata),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .rs1_hit_o(hit1), .rs1_data_o(bd1),
    .rs2_hit_o(hit2), .rs2_data_o(bd2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: a queue of pending long-latency results
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  bit          can_acc;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_pend = '0;
    end else begin
      can_acc = q.size() < DEPTH;
      if (alu_valid && alu_rd != 0) begin
        m_we = 1'b1;
        m_addr = alu_rd;
        m_data = alu_data;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_we = 1'b1;
        m_addr = e.rd;
        m_data = e.d;
        m_pend[e.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (ll_valid && can_acc && ll_rd != 0) q.push_back('{ll_rd, ll_data});
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic h1, h2;
      h1 = BYP && m_we && m_addr != 0 && rs1 == m_addr;
      h2 = BYP && m_we && m_addr != 0 && rs2 == m_addr;
      chk("m_we", 64'(we), 64'(m_we));
      chk("m_addr", 64'(waddr), 64'(m_addr));
      chk("m_data", 64'(wdata), 64'(m_data));
      chk("m_pend", 64'(pend), 64'(m_pend));
      chk("m_ready", 64'(ll_ready), 64'(!rst && q.size() < DEPTH));
      chk("m_hit1", 64'(hit1), 64'(h1));
      chk("m_hit2", 64'(hit2), 64'(h2));
      chk("m_bd1", 64'(bd1), h1 ? 64'(m_data) : 64'd0);
      chk("m_bd2", 64'(bd2), h2 ? 64'(m_data) : 64'd0);
    end
  end

  initial begin
    step();
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_we", 64'(we), 0);
    chk("rst_pend", 64'(pend), 0);
    chk("rst_ready", 64'(ll_ready), 1);

    // ALU write and rd=0 idle slot
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we", 64'(we), 1);
    chk("alu_addr", 64'(waddr), 5);
    chk("alu_data", 64'(wdata), 64'hDEADBEEF);
    alu_rd = 5'd0;
    step();
    chk("rd0_we", 64'(we), 0);
    chk("rd0_hold", 64'(waddr), 5);
    alu_valid = 1'b0;

    // priority: ALU holds off the FIFO drain
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("iss_pend7", 64'(pend[7]), 1);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h11;
    step();
    ll_valid = 1'b0;
    step();
    step();
    chk("pri_pend7", 64'(pend[7]), 1);
    chk("pri_addr", 64'(waddr), 1);
    alu_valid = 1'b0;
    step();
    chk("drn_addr", 64'(waddr), 7);
    chk("drn_data", 64'(wdata), 64'h11);
    chk("drn_pend7", 64'(pend[7]), 0);

    // full FIFO then ordered drain
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
    for (int i = 1; i <= 4; i++) begin
      chk("fill_ready", 64'(ll_ready), 1);
      ll_valid = 1'b1; ll_rd = 5'(i); ll_data = 32'h100 + 32'(i);
      step();
    end
    ll_valid = 1'b0;
    chk("full_ready", 64'(ll_ready), 0);
    step();
    chk("full_hold", 64'(ll_ready), 0);
    alu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("ord_addr", 64'(waddr), 64'(i));
      chk("ord_data", 64'(wdata), 64'h100 + 64'(i));
      chk("ord_ready", 64'(ll_ready), 1);
    end
    step();
    chk("empty_we", 64'(we), 0);

    // set/clear collision on rd 9
    issue_valid = 1'b1; issue_rd = 5'd9;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    step();
    ll_valid = 1'b0;
    step();
    issue_valid = 1'b0;
    chk("col_addr", 64'(waddr), 9);
    chk("col_pend9", 64'(pend[9]), 1);

    // async reset mid-drain
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1'b1; ll_rd = 5'(10 + i); ll_data = 32'(i);
      step();
    end
    ll_valid = 1'b0; alu_valid = 1'b0;
    step();
    chk("mid_we", 64'(we), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 64'(we), 0);
    chk("arst_pend", 64'(pend), 0);
    chk("arst_ready", 64'(ll_ready), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_we", 64'(we), 0);
    chk("post_ready", 64'(ll_ready), 1);

    // bypass
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h42;
    rs1 = 5'd3; rs2 = 5'd0;
    step();
    alu_valid = 1'b0;
    chk("byp_hit1", 64'(hit1), 64'(BYP));
    chk("byp_bd1", 64'(bd1), BYP ? 64'h42 : 64'd0);
    chk("byp_hit2", 64'(hit2), 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      alu_valid   = ($urandom_range(0, 99) < 45);
      alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_data    = $urandom;
      ll_valid    = ($urandom_range(0, 99) < 40);
      ll_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      ll_data     = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_rd    = 5'($urandom);
      rs1         = 5'($urandom);
      rs2         = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
